// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision floating-point multiplier.
package fp_pkg;

  localparam int SIGN_W  = 1;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int FP_W    = SIGN_W + EXP_W + MAN_W;

  localparam int BIAS    = 127;
  localparam int EXP_INF = 255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    MULT,
    NORM,
    ROUND,
    PACK,
    DONE
  } state_t;

endpackage

// File: rtl/fp_mul_mul24_seq.sv
// Iterative 24x24 shift-add multiplier. The start edge loads the operands and
// already folds in multiplier bit 0; the following 23 busy cycles each add one
// more bit, so the product is complete on the edge that clears busy.
module mul24_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] mcand,
  input  logic [23:0] mplier,
  output logic        busy,
  output logic [47:0] product
);

  logic [47:0] r_acc;
  logic [47:0] r_mcand;
  logic [23:0] r_mplier;
  logic [4:0]  r_cnt;
  logic        r_busy;

  // Load on start, then one conditional add and shift per busy cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_acc    <= mplier[0] ? {24'd0, mcand} : 48'd0;
      r_mcand  <= {23'd0, mcand, 1'b0};
      r_mplier <= {1'b0, mplier[23:1]};
      r_cnt    <= 5'd23;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= {r_mcand[46:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[23:1]};
      r_cnt    <= r_cnt - 5'd1;
      if (r_cnt == 5'd1) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy    = r_busy;
  assign product = r_acc;

endmodule

// File: rtl/fp_mul.sv
// IEEE-754 single-precision multiplier: multi-cycle FSM around a sequential
// mantissa multiplier, with round-to-nearest-even and flush-to-zero.
module fp_mul
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] z,
  output logic            done
);

  localparam logic signed [9:0] C_BIAS    = 10'(BIAS);
  localparam logic signed [9:0] C_EXP_INF = 10'(EXP_INF);

  state_t                  r_state;
  logic [FP_W-1:0]         r_a;
  logic [FP_W-1:0]         r_b;
  logic                    r_sign;
  logic signed [9:0]       r_exp;
  logic [46:0]             r_norm;
  logic [MAN_W-1:0]        r_mant;
  logic [FP_W-1:0]         r_z;
  logic                    r_done;

  logic [EXP_W-1:0]        w_ea;
  logic [EXP_W-1:0]        w_eb;
  logic [MAN_W-1:0]        w_fa;
  logic [MAN_W-1:0]        w_fb;
  logic                    w_sign;
  logic                    w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic                    w_special;
  logic [FP_W-1:0]         w_spec_z;
  logic                    w_start;
  logic                    w_busy;
  logic [47:0]             w_prod;
  logic [24:0]             w_rnd;

  // Round-to-nearest-even on a product whose leading one sits at bit 46.
  // Returns the 24-bit significand plus a carry-out bit.
  function automatic logic [24:0] round_rne(input logic [46:0] p);
    logic lsb, g, r, s, up;
    lsb = p[23];
    g   = p[22];
    r   = p[21];
    s   = |p[20:0];
    up  = g & (r | s | lsb);
    return {1'b0, p[46:23]} + {24'd0, up};
  endfunction

  // Final packing with overflow to infinity and underflow flushed to zero.
  function automatic logic [FP_W-1:0] pack_fp(input logic s,
                                               input logic signed [9:0] e,
                                               input logic [MAN_W-1:0] m);
    if (e >= C_EXP_INF)
      return {s, EXP_W'(EXP_INF), {MAN_W{1'b0}}};
    else if (e <= 10'sd0)
      return {s, {(EXP_W+MAN_W){1'b0}}};
    else
      return {s, e[EXP_W-1:0], m};
  endfunction

  assign w_ea     = r_a[MAN_W +: EXP_W];
  assign w_eb     = r_b[MAN_W +: EXP_W];
  assign w_fa     = r_a[MAN_W-1:0];
  assign w_fb     = r_b[MAN_W-1:0];
  assign w_sign   = r_a[FP_W-1] ^ r_b[FP_W-1];
  assign w_a_nan  = (w_ea == EXP_W'(EXP_INF)) && (w_fa != '0);
  assign w_b_nan  = (w_eb == EXP_W'(EXP_INF)) && (w_fb != '0);
  assign w_a_inf  = (w_ea == EXP_W'(EXP_INF)) && (w_fa == '0);
  assign w_b_inf  = (w_eb == EXP_W'(EXP_INF)) && (w_fb == '0);
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
  assign w_start  = (r_state == UNPACK) && !w_special;
  assign w_rnd    = round_rne(r_norm);

  // Result for operands that bypass the datapath (NaN, infinity, zero/denormal)
  always_comb begin
    w_spec_z = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      w_spec_z = QNAN;
    else if (w_a_inf || w_b_inf)
      w_spec_z = {w_sign, EXP_W'(EXP_INF), {MAN_W{1'b0}}};
    else
      w_spec_z = {w_sign, {(EXP_W+MAN_W){1'b0}}};
  end

  mul24_seq u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_start),
    .mcand   ({1'b1, w_fa}),
    .mplier  ({1'b1, w_fb}),
    .busy    (w_busy),
    .product (w_prod)
  );

  // Control FSM with registered result and done flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_norm  <= '0;
      r_mant  <= '0;
      r_z     <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en) begin
            r_a     <= a;
            r_b     <= b;
            r_state <= UNPACK;
          end
        end
        UNPACK: begin
          r_sign <= w_sign;
          r_exp  <= $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - C_BIAS;
          if (w_special) begin
            r_z     <= w_spec_z;
            r_state <= DONE;
          end else begin
            r_state <= MULT;
          end
        end
        MULT: begin
          if (!w_busy) begin
            r_state <= NORM;
          end
        end
        NORM: begin
          // Keep the bit shifted out as part of the sticky information
          if (w_prod[47]) begin
            r_norm <= {w_prod[47:2], w_prod[1] | w_prod[0]};
            r_exp  <= r_exp + 10'sd1;
          end else begin
            r_norm <= w_prod[46:0];
          end
          r_state <= ROUND;
        end
        ROUND: begin
          if (w_rnd[24]) begin
            r_mant <= w_rnd[23:1];
            r_exp  <= r_exp + 10'sd1;
          end else begin
            r_mant <= w_rnd[22:0];
          end
          r_state <= PACK;
        end
        PACK: begin
          r_z     <= pack_fp(r_sign, r_exp, r_mant);
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          // Special-case results arrive here with done still low; raise it
          // unconditionally so a dropped en cannot swallow the result.
          if (!r_done) begin
            r_done <= 1'b1;
          end else if (!en) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign z    = r_z;
  assign done = r_done;

endmodule

// File: tb/tb_fp_mul.sv
// Directed self-checking bench for fp_mul with a scoreboard of expected results.
module tb_fp_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] z;
  logic        done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] z;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];

  fp_mul dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .a    (a),
    .b    (b),
    .z    (z),
    .done (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Wait (bounded) for done after a capture edge; returns edges counted.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Run one operation; hold keeps en high through completion.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] expz, input int explat,
                       input string tag, input bit hold);
    int   lat;
    exp_t e;
    @(negedge clk);
    en = 1'b1;
    a  = av;
    b  = bv;
    @(posedge clk);
    sb.push_back('{z: expz, lat: explat, tag: tag});
    #1;
    if (!hold) en = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_done(lat);
    e = sb.pop_front();
    chk({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
    chk({e.tag, "_z"}, z, e.z);
    if (!hold) begin
      @(posedge clk);
      #1;
      chk({e.tag, "_done_drop"}, {31'd0, done}, 32'd0);
      chk({e.tag, "_z_retained"}, z, e.z);
    end
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1;
    en  = 1'b0;
    a   = '0;
    b   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_z", z, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;

    // Normal-path products
    do_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 28, "two_x_three", 1'b0);
    do_op(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 28, "rne_sticky", 1'b0);
    do_op(32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 28, "neg_half", 1'b0);
    do_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 28, "overflow", 1'b0);
    do_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 28, "underflow", 1'b0);
    do_op(32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 28, "max_mant", 1'b0);

    // Special cases resolved in UNPACK
    do_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 2, "inf_x_zero", 1'b0);
    do_op(32'h7FC0_1234, 32'h3F80_0000, 32'h7FC0_0000, 2, "nan_in", 1'b0);
    do_op(32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 2, "inf_x_neg", 1'b0);
    do_op(32'h0000_0000, 32'hC040_0000, 32'h8000_0000, 2, "zero_x_neg", 1'b0);
    do_op(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 2, "denorm_zero", 1'b0);

    // Reset during MULT, with en high to show reset wins
    @(negedge clk);
    en = 1'b1;
    a  = 32'h4000_0000;
    b  = 32'h4000_0000;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_z", z, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    saw_done = 1'b0;
    repeat (32) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("midreset_no_done", {31'd0, saw_done}, 32'd0);
    do_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 28, "after_reset", 1'b0);

    // Handshake: hold en through done, release one cycle, restart
    do_op(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 28, "hold", 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_z", z, 32'h4110_0000);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("release_done", {31'd0, done}, 32'd0);
    chk("release_z", z, 32'h4110_0000);
    do_op(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 28, "recapture", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_mul.md
FP_MUL -- requirements
Module: fp_mul

Interface
REQ-001 The block SHALL have no parameters; the format is fixed at IEEE-754 single precision, 32 bits.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 en  input  1  start request, level-sensitive; a and b are captured when en is seen high in IDLE.
REQ-005 a  input  32  operand A, IEEE-754 single.
REQ-006 b  input  32  operand B, IEEE-754 single.
REQ-007 z  output  32  product, registered; valid while done=1.
REQ-008 done  output  1  result-valid flag, registered.

Function
REQ-009 FSM states SHALL be IDLE, UNPACK, MULT, NORM, ROUND, PACK and DONE.
REQ-010 IDLE: if en=1, the block SHALL capture a and b and go to UNPACK; otherwise it SHALL stay in IDLE.
REQ-011 UNPACK (1 cycle): split sign, exponent and mantissa, with the hidden 1 for exp≠0; exp=0 inputs (zero or denormal) SHALL be treated as signed zero.
REQ-012 Special cases SHALL be resolved in UNPACK and go straight to DONE, so done rises 2 cycles after capture:
- any NaN operand, or inf×0 -> 0x7FC00000
- inf×nonzero -> signed inf
- zero×finite -> signed zero
REQ-013 Result sign SHALL be sign(a) XOR sign(b) in every non-NaN case.
REQ-014 MULT SHALL form the 48-bit mantissa product with an iterative shift-add, one bit per cycle, 24 cycles.
REQ-015 Exponent SHALL be ea+eb-127, computed in 10-bit signed arithmetic.
REQ-016 NORM (1 cycle): if product bit 47=1, shift right by 1 and add 1 to the exponent.
REQ-017 ROUND (1 cycle): round to nearest even, using guard, round and sticky bits taken from the discarded low bits.
REQ-018 If rounding carries out of the mantissa, the mantissa SHALL be shifted right and the exponent incremented.
REQ-019 PACK (1 cycle): exponent ≥255 -> signed inf; exponent ≤0 -> signed zero (flush, no denormal outputs); otherwise pack normally.
REQ-020 Normal path SHALL assert done exactly 28 cycles after the capture edge.
REQ-021 DONE: z and done=1 SHALL hold while en=1; on the first edge with en=0, done SHALL drop and the FSM SHALL return to IDLE, with z retaining its value.
REQ-022 A new operation SHALL require en low for at least one cycle after done.
REQ-023 Deasserting en mid-operation SHALL NOT abort it; the operation completes.
REQ-024 Changes on a and b after capture SHALL NOT affect the result.

Reset
REQ-025 When rst=1 at a rising edge: state=IDLE, z=0, done=0, all internal registers cleared.
REQ-026 Reset SHALL apply from any state, including mid-MULT.
REQ-027 rst SHALL take priority over en.

Structure
REQ-028 A shared package fp_pkg SHALL hold: the state enum, BIAS=127, EXP_INF=255, QNAN=32'h7FC00000, and the field widths (1/8/23).
REQ-029 The 24x24 iterative multiplier SHALL be the sub-module mul24_seq, with start, busy and 48-bit product ports, instantiated once.
REQ-030 Rounding and packing logic SHALL stay in fp_mul.

Verification
REQ-031 a=0x40000000, b=0x40400000 (2×3) -> z=0x40C00000, done rises 28 cycles after capture.
REQ-032 a=0x3F800001, b=0x3F800001 -> z=0x3F800002 (exercises round-to-nearest-even / sticky).
REQ-033 a=0xC0000000, b=0x3F000000 -> z=0xBF800000; a=0x7F000000, b=0x7F000000 -> z=0x7F800000 (overflow).
REQ-034 a=0x7F800000, b=0x00000000 -> z=0x7FC00000, done 2 cycles after capture.
REQ-035 rst pulsed during MULT -> next edge done=0, z=0, state IDLE; a following operation 0x3FC00000×0x3FC00000 -> z=0x40100000.
REQ-036 Handshake: en held high after done -> done and z stable; en low one cycle -> done=0; en high again -> new capture.
